// File: rtl/program_loader_pkg.sv
// Shared types and default sizes for the program loader.
// Contents: loader FSM state encoding and default geometry of the 16x8 program RAM.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/program_loader_checksum_acc.sv
// Running modulo-2**W sum of the image bytes written by the loader.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         zero the sum (start of a new load)
//   add_en        add data_byte to the sum this cycle
//   data_byte     byte being accepted into the image
//   sum           current running sum
module loader_checksum_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] data_byte,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data_byte;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: fills the CPU's program RAM from a byte stream.
// Holds the CPU for the whole load, writes DEPTH bytes to addresses
// 0..DEPTH-1, then pulses done for one cycle and releases the CPU.
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to accept one extra
// check byte after the image; the mod-2**DATA_W sum of image + check byte
// must be zero, otherwise error is raised (sticky until the next start).
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   start         begin a load (only looked at in IDLE)
//   in_valid      stream byte present
//   in_data       stream byte
//   in_ready      loader takes a byte this cycle
//   mem_write     registered RAM write strobe
//   mem_addr      registered RAM address
//   mem_data      registered RAM write data
//   cpu_hold      CPU stalled, loader owns the RAM port
//   busy          loader in LOAD or CHECK
//   done          one-cycle end-of-load pulse
//   error         checksum mismatch (always 0 without the checksum feature)
//   dbg_state     current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the FSM state, never on in_valid, so
// the source may hold in_valid/in_data until it sees the transfer.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        dbg_state
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] count;
  logic              start_load;
  logic              load_accept;
  logic              last_word;

  assign start_load  = (state == IDLE) && start;
  assign load_accept = (state == LOAD) && in_valid;
  assign last_word   = (count == ADDR_W'(DEPTH - 1));
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
      CHECK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = DONE;
      end
      DONE: begin
        // Hold stays up here: the final image byte is on the RAM port this cycle.
        cpu_hold  = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      state     <= state_nxt;
      mem_write <= load_accept;
      if (start_load) begin
        count <= '0;
      end
      // Address/data only move on an accept, so after a full image they rest
      // at the last word; count has already wrapped to 0 for the next load.
      if (load_accept) begin
        mem_addr <= count;
        mem_data <= in_data;
        count    <= count + ADDR_W'(1);
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] total;
  logic              check_accept;

  assign check_accept = (state == CHECK) && in_valid;
  assign total        = sum + in_data;

  loader_checksum_acc #(.W(DATA_W)) u_checksum_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start_load),
    .add_en    (load_accept),
    .data_byte (in_data),
    .sum       (sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (start_load) begin
      error <= 1'b0;
    end else if (check_accept) begin
      error <= (total != '0);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (default geometry 16x8).
// Drivers push the expected {addr,data} of every write into exp_q when the
// byte is accepted; the negedge monitor pops and compares on each mem_write.
module tb_program_loader;
  import program_loader_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_write;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] dbg_state;

  program_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [11:0] exp_q[$];
  int          wr_count = 0;
  int          done_count = 0;
  int          streak = 0;
  int          max_streak = 0;
  logic [15:0] wr_mask = 16'h0000;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (start) begin
      streak     = 0;
      max_streak = 0;
      wr_mask    = 16'h0000;
    end
    if (mem_write) begin
      wr_count++;
      streak++;
      if (streak > max_streak) max_streak = streak;
      wr_mask[mem_addr] = 1'b1;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[11:8]));
        chk("write_data", 32'(mem_data), 32'(e[7:0]));
      end
    end else begin
      streak = 0;
    end
    if (prev_done) chk("hold_released_after_done", 32'(cpu_hold), 32'd0);
    if (done) begin
      done_count++;
      chk("hold_during_done", 32'(cpu_hold), 32'd1);
      chk("ready_low_in_done", 32'(in_ready), 32'd0);
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte; wr=1 means it must appear on the RAM port at address a.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] a, input bit wr);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        if (wr) exp_q.push_back({a, d});
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic end_load(input logic [7:0] check_byte);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(check_byte, 4'd0, 1'b0);
`else
    if (check_byte == 8'hFF) tick();
`endif
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
    tick();
    chk("idle_after_done", 32'(dbg_state), 32'(IDLE));
    chk("busy_low_after_done", 32'(busy), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int w0;

    // 1: asynchronous reset, mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({in_ready, mem_write, cpu_hold, busy, done, error, mem_addr, mem_data}), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // 2: full load 0x10..0x1F, continuous valid
    d0 = done_count;
    do_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 4'(i), 1'b1);
    end_load(8'h88);
    wait_done("full_done");
    chk("full_write_streak", 32'(max_streak), 32'd16);
    chk("full_done_count", 32'(done_count - d0), 32'd1);
    chk("full_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("full_addr_rests_at_15", 32'(mem_addr), 32'd15);

    // 3: gapped stream, valid 1,0,1,0...
    do_start();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h40 + 3 * i), 4'(i), 1'b1);
      if (i < 15) tick();
    end
    end_load(8'h00);
    wait_done("gap_done");
    chk("gap_write_streak", 32'(max_streak), 32'd1);
    chk("gap_all_addrs", 32'(wr_mask), 32'h0000FFFF);
    chk("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: abort after 5 bytes, then restart from address 0
    do_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 4'(i), 1'b1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_hold_released", 32'(cpu_hold), 32'd0);
    chk("abort_outputs", 32'({in_ready, mem_write, busy, done, mem_addr, mem_data}), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_written_mask", 32'(wr_mask), 32'h0000001F);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i), 4'(i), 1'b1);
    end_load(8'h78);
    wait_done("restart_done");
    chk("restart_all_addrs", 32'(wr_mask), 32'h0000FFFF);

    // 5: start during LOAD ignored; valid in IDLE ignored
    do_start();
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 4'(i), 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_load_busy", 32'(busy), 32'd1);
    chk("start_in_load_state", 32'(dbg_state), 32'(LOAD));
    for (int i = 3; i < 16; i++) send_byte(8'(8'hC0 + i), 4'(i), 1'b1);
    end_load(8'h00);
    wait_done("ignored_start_done");
    w0 = wr_count;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int j = 0; j < 3; j++) begin
      chk("idle_ready_low", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("idle_no_writes", 32'(wr_count - w0), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // 6: checksum 16x0x01 + 0xF0 good, + 0xF1 bad (sticky until start)
    do_start();
    for (int i = 0; i < 16; i++) send_byte(8'h01, 4'(i), 1'b1);
    send_byte(8'hF0, 4'd0, 1'b0);
    chk("csum_good_done", 32'(done), 32'd1);
    chk("csum_good_error", 32'(error), 32'd0);
    wait_done("csum_good_done_seen");
    do_start();
    for (int i = 0; i < 16; i++) send_byte(8'h01, 4'(i), 1'b1);
    send_byte(8'hF1, 4'd0, 1'b0);
    chk("csum_bad_error_in_done", 32'(error), 32'd1);
    wait_done("csum_bad_done_seen");
    tick();
    tick();
    chk("csum_bad_error_sticky", 32'(error), 32'd1);
    do_start();
    chk("csum_error_cleared_by_start", 32'(error), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'h01, 4'(i), 1'b1);
    send_byte(8'hF0, 4'd0, 1'b0);
    wait_done("csum_final_done");
    chk("csum_final_error", 32'(error), 32'd0);
`endif

    tick();
    tick();
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
